eth_rx_fcs_checker: RTL

- Byte-wide AXI-Stream stage directly upstream of the RX async FIFO's write (slave) side, in the MAC RX clock domain.
- Computes the Ethernet CRC-32 over each received frame, strips the 4-byte FCS and passes the payload through.
- On the final beat it asserts tuser if the frame is bad, which makes the downstream FIFO roll back to its last committed frame.
- Bad means: FCS mismatch, PHY error, or length out of range.

---
 rtl/eth_rx_fcs_checker_if.sv | 27 ++
 rtl/eth_rx_fcs_checker.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/eth_rx_fcs_checker_if.sv
// Byte-wide AXI-Stream bundle for the RX FCS checker.
// Ports: tdata/tvalid/tlast/tuser forward, trdy backward; master/slave modports.
interface eth_rx_fcs_checker_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tlast;
    logic                  tuser;
    logic                  trdy;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        output tuser,
        input  trdy
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        input  tuser,
        output trdy
    );
endinterface

// File: rtl/eth_rx_fcs_checker.sv
// RX FCS checker: CRC-32 check, FCS strip, bad-frame flag on the last payload beat.
// Ports: clk, reset (async, active-high), s_axis (slave, bytes incl. FCS),
// m_axis (master, payload only, tuser=bad on tlast).
// Macro ETH_RX_FCS_STATS_EN adds stat_good_frames/stat_bad_frames/stat_runt_drops.
module eth_rx_fcs_checker #(
    parameter int DATA_WIDTH      = 8,
    parameter int MIN_FRAME_BYTES = 60,
    parameter int MAX_FRAME_BYTES = 1514,
    parameter int LEN_WIDTH       = 11
) (
    input  logic clk,
    input  logic reset,
    eth_rx_fcs_checker_if.slave  s_axis,
    eth_rx_fcs_checker_if.master m_axis
`ifdef ETH_RX_FCS_STATS_EN
    ,
    output logic [31:0] stat_good_frames,
    output logic [31:0] stat_bad_frames,
    output logic [31:0] stat_runt_drops
`endif
);
    localparam logic [0:0] ST_FILL   = 1'b0;
    localparam logic [0:0] ST_STREAM = 1'b1;

    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

    localparam logic [LEN_WIDTH-1:0] LEN_MAX = '1;

    logic [0:0]            state;
    logic [2:0]            fill_cnt;
    logic [DATA_WIDTH-1:0] delay [4];
    logic [31:0]           crc;
    logic [LEN_WIDTH-1:0]  len;
    logic                  err;

    logic                  accept;
    logic                  emit;
    logic                  len_sat;
    logic                  bad;
    logic [31:0]           crc_next;
    logic [LEN_WIDTH-1:0]  len_next;
    logic [31:0]           pay_len;

    function automatic logic [31:0] crc_byte(
        input logic [31:0] c,
        input logic [7:0]  d
    );
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
        end
        return r;
    endfunction

    assign s_axis.trdy = !m_axis.tvalid | m_axis.trdy;
    assign accept      = s_axis.tvalid & s_axis.trdy;
    assign emit        = accept & (state == ST_STREAM);

    assign crc_next = crc_byte(crc, s_axis.tdata);
    assign len_next = (len == LEN_MAX) ? len : len + 1'b1;
    assign len_sat  = (len_next == LEN_MAX);
    // Only consulted while streaming, where len_next >= 5.
    assign pay_len  = 32'(len_next) - 32'd4;

    assign bad = (crc_next != CRC_RESIDUE)
               | err
               | s_axis.tuser
               | (pay_len < 32'(MIN_FRAME_BYTES))
               | (pay_len > 32'(MAX_FRAME_BYTES))
               | len_sat;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_FILL;
            fill_cnt <= '0;
            crc      <= CRC_INIT;
            len      <= '0;
            err      <= 1'b0;
        end else if (accept) begin
            if (s_axis.tlast) begin
                // Next frame may start on the following beat.
                state    <= ST_FILL;
                fill_cnt <= '0;
                crc      <= CRC_INIT;
                len      <= '0;
                err      <= 1'b0;
            end else begin
                crc <= crc_next;
                len <= len_next;
                err <= err | s_axis.tuser;
                if (state == ST_FILL) begin
                    fill_cnt <= fill_cnt + 3'd1;
                    if (fill_cnt == 3'd3) begin
                        state <= ST_STREAM;
                    end
                end
            end
        end
    end

    // Four-byte delay line holds back the FCS from the output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                delay[i] <= '0;
            end
        end else if (accept) begin
            delay[0] <= s_axis.tdata;
            for (int i = 1; i < 4; i++) begin
                delay[i] <= delay[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_axis.tdata  <= '0;
            m_axis.tvalid <= 1'b0;
            m_axis.tlast  <= 1'b0;
            m_axis.tuser  <= 1'b0;
        end else if (emit) begin
            m_axis.tdata  <= delay[3];
            m_axis.tvalid <= 1'b1;
            m_axis.tlast  <= s_axis.tlast;
            m_axis.tuser  <= s_axis.tlast & bad;
        end else if (m_axis.trdy) begin
            m_axis.tvalid <= 1'b0;
            m_axis.tlast  <= 1'b0;
            m_axis.tuser  <= 1'b0;
        end
    end

`ifdef ETH_RX_FCS_STATS_EN
    logic runt;
    logic out_eof;

    assign runt    = accept & s_axis.tlast & (state == ST_FILL);
    assign out_eof = m_axis.tvalid & m_axis.trdy & m_axis.tlast;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_good_frames <= '0;
            stat_bad_frames  <= '0;
            stat_runt_drops  <= '0;
        end else begin
            if (out_eof & !m_axis.tuser) begin
                stat_good_frames <= stat_good_frames + 32'd1;
            end
            if (out_eof & m_axis.tuser) begin
                stat_bad_frames <= stat_bad_frames + 32'd1;
            end
            if (runt) begin
                stat_runt_drops <= stat_runt_drops + 32'd1;
            end
        end
    end
`endif
endmodule
